// File: rtl/multicycle_main_control_if.sv
// Control bundle between the multi-cycle main control FSM and the datapath.
// The controller side (master) reads the IR opcode and memory ready, and drives every control line.
interface multicycle_main_control_if;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal_op;
   logic [3:0] state;

   modport master (
      input  opcode, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state
   );

   modport slave (
      output opcode, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state
   );
endinterface

// File: rtl/multicycle_main_control.sv
// Main control FSM of the multi-cycle MIPS-subset CPU: decodes the opcode and
// sequences the datapath, stalling in FETCH/MEM_RD/MEM_WR until memory is ready.
module multicycle_main_control #(
   parameter logic [5:0] OP_RTYPE = 6'd0,
   parameter logic [5:0] OP_LW    = 6'd35,
   parameter logic [5:0] OP_SW    = 6'd43,
   parameter logic [5:0] OP_BEQ   = 6'd4,
   parameter logic [5:0] OP_J     = 6'd2,
   parameter logic [5:0] OP_ADDI  = 6'd8
) (
   input  logic                               clk,
   input  logic                               rst,
   multicycle_main_control_if.master          bus
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_LW_WB    = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EXEC   = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11
   } state_t;

   state_t     r_state;
   state_t     w_next;

   logic       w_pc_write;
   logic       w_pc_write_cond;
   logic       w_i_or_d;
   logic       w_mem_read;
   logic       w_mem_write;
   logic       w_ir_write;
   logic       w_mem_to_reg;
   logic       w_reg_dst;
   logic       w_reg_write;
   logic       w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_op;
   logic [1:0] w_pc_source;
   logic       w_illegal_op;

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   // NOTE: every signal gets a default before the case, so no path can infer a latch.
   always_comb begin
      w_next          = S_FETCH;
      w_pc_write      = 1'b0;
      w_pc_write_cond = 1'b0;
      w_i_or_d        = 1'b0;
      w_mem_read      = 1'b0;
      w_mem_write     = 1'b0;
      w_ir_write      = 1'b0;
      w_mem_to_reg    = 1'b0;
      w_reg_dst       = 1'b0;
      w_reg_write     = 1'b0;
      w_alu_src_a     = 1'b0;
      w_alu_src_b     = 2'b00;
      w_alu_op        = 2'b00;
      w_pc_source     = 2'b00;
      w_illegal_op    = 1'b0;

      case (r_state)
         S_FETCH: begin
            w_mem_read  = 1'b1;
            w_alu_src_b = 2'b01;
            // IR and PC+4 commit only on the cycle the read actually completes
            w_ir_write  = bus.mem_ready;
            w_pc_write  = bus.mem_ready;
            w_next      = bus.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            w_alu_src_b = 2'b11;
            if (bus.opcode == OP_LW || bus.opcode == OP_SW) w_next = S_MEM_ADDR;
            else if (bus.opcode == OP_RTYPE)                w_next = S_R_EXEC;
            else if (bus.opcode == OP_BEQ)                  w_next = S_BRANCH;
            else if (bus.opcode == OP_J)                    w_next = S_JUMP;
            else if (bus.opcode == OP_ADDI)                 w_next = S_ADDI_EX;
            else begin
               w_illegal_op = 1'b1;
               w_next       = S_FETCH;
            end
         end
         S_MEM_ADDR: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            if (bus.opcode == OP_LW)      w_next = S_MEM_RD;
            else if (bus.opcode == OP_SW) w_next = S_MEM_WR;
            else                          w_next = S_FETCH;
         end
         S_MEM_RD: begin
            w_mem_read = 1'b1;
            w_i_or_d   = 1'b1;
            w_next     = bus.mem_ready ? S_LW_WB : S_MEM_RD;
         end
         S_LW_WB: begin
            w_mem_to_reg = 1'b1;
            w_reg_write  = 1'b1;
         end
         S_MEM_WR: begin
            w_mem_write = 1'b1;
            w_i_or_d    = 1'b1;
            w_next      = bus.mem_ready ? S_FETCH : S_MEM_WR;
         end
         S_R_EXEC: begin
            w_alu_src_a = 1'b1;
            w_alu_op    = 2'b10;
            w_next      = S_R_WB;
         end
         S_R_WB: begin
            w_reg_dst   = 1'b1;
            w_reg_write = 1'b1;
         end
         S_BRANCH: begin
            w_alu_src_a     = 1'b1;
            w_alu_op        = 2'b01;
            w_pc_write_cond = 1'b1;
            w_pc_source     = 2'b01;
         end
         S_JUMP: begin
            w_pc_write  = 1'b1;
            w_pc_source = 2'b10;
         end
         S_ADDI_EX: begin
            w_alu_src_a = 1'b1;
            w_alu_src_b = 2'b10;
            w_next      = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            w_reg_write = 1'b1;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Reset holds every control line low so nothing is written while rst is high
   assign bus.pc_write      = w_pc_write      & ~rst;
   assign bus.pc_write_cond = w_pc_write_cond & ~rst;
   assign bus.i_or_d        = w_i_or_d        & ~rst;
   assign bus.mem_read      = w_mem_read      & ~rst;
   assign bus.mem_write     = w_mem_write     & ~rst;
   assign bus.ir_write      = w_ir_write      & ~rst;
   assign bus.mem_to_reg    = w_mem_to_reg    & ~rst;
   assign bus.reg_dst       = w_reg_dst       & ~rst;
   assign bus.reg_write     = w_reg_write     & ~rst;
   assign bus.alu_src_a     = w_alu_src_a     & ~rst;
   assign bus.alu_src_b     = rst ? 2'b00 : w_alu_src_b;
   assign bus.alu_op        = rst ? 2'b00 : w_alu_op;
   assign bus.pc_source     = rst ? 2'b00 : w_pc_source;
   assign bus.illegal_op    = w_illegal_op    & ~rst;
   assign bus.state         = rst ? 4'd0 : r_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: walks each instruction class
// through its state sequence and compares state and the full control word.
module tb_multicycle_main_control;

   logic clk = 1'b0;
   logic rst;
   int   n_checks   = 0;
   int   n_failures = 0;

   multicycle_main_control_if bus ();

   multicycle_main_control dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Control word: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
   //   ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
   //   alu_op[1:0], pc_source[1:0], illegal_op}
   logic [16:0] obs_ctl;
   assign obs_ctl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                     bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.pc_source, bus.illegal_op};

   //                                   pw pwc iod mr mw irw m2r rd rw asa asb aop ps ill
   localparam logic [16:0] C_ZERO    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] C_FET_RDY = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
   localparam logic [16:0] C_FET_WT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
   localparam logic [16:0] C_DEC     = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
   localparam logic [16:0] C_DEC_ILL = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
   localparam logic [16:0] C_MADDR   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [16:0] C_MRD     = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] C_LWWB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
   localparam logic [16:0] C_MWR     = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] C_REXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
   localparam logic [16:0] C_RWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
   localparam logic [16:0] C_BRANCH  = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [16:0] C_JUMP    = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
   localparam logic [16:0] C_ADDIEX  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [16:0] C_ADDIWB  = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

   task automatic check(input string tag, input logic [16:0] observed,
                        input logic [16:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_failures++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Inputs are already applied; let them settle, compare, then move to 1ns past the next edge.
   task automatic cyc(input string tag, input logic [3:0] exp_state,
                      input logic [16:0] exp_ctl);
      #1;
      check({tag, "_state"}, {13'd0, bus.state}, {13'd0, exp_state});
      check({tag, "_ctl"},   obs_ctl,            exp_ctl);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst           = 1'b1;
      bus.opcode    = 6'd0;
      bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset: everything low, even with mem_ready high
      cyc("rst_a", 4'd0, C_ZERO);
      bus.mem_ready = 1'b1;
      cyc("rst_b", 4'd0, C_ZERO);

      // R-type with zero-wait memory
      rst = 1'b0; bus.opcode = 6'd0;
      cyc("r_fetch",  4'd0, C_FET_RDY);
      cyc("r_decode", 4'd1, C_DEC);
      cyc("r_exec",   4'd6, C_REXEC);
      cyc("r_wb",     4'd7, C_RWB);

      // lw with two wait cycles in MEM_RD
      bus.opcode = 6'd35;
      cyc("lw_fetch",  4'd0, C_FET_RDY);
      cyc("lw_decode", 4'd1, C_DEC);
      cyc("lw_addr",   4'd2, C_MADDR);
      bus.mem_ready = 1'b0;
      cyc("lw_rd_w1",  4'd3, C_MRD);
      cyc("lw_rd_w2",  4'd3, C_MRD);
      bus.mem_ready = 1'b1;
      cyc("lw_rd_ok",  4'd3, C_MRD);
      cyc("lw_wb",     4'd4, C_LWWB);

      // sw with one wait cycle in MEM_WR
      bus.opcode = 6'd43;
      cyc("sw_fetch",  4'd0, C_FET_RDY);
      cyc("sw_decode", 4'd1, C_DEC);
      cyc("sw_addr",   4'd2, C_MADDR);
      bus.mem_ready = 1'b0;
      cyc("sw_wr_w1",  4'd5, C_MWR);
      bus.mem_ready = 1'b1;
      cyc("sw_wr_ok",  4'd5, C_MWR);

      // beq, preceded by one FETCH wait cycle
      bus.opcode = 6'd4; bus.mem_ready = 1'b0;
      cyc("beq_fetch_w", 4'd0, C_FET_WT);
      bus.mem_ready = 1'b1;
      cyc("beq_fetch",   4'd0, C_FET_RDY);
      cyc("beq_decode",  4'd1, C_DEC);
      cyc("beq_branch",  4'd8, C_BRANCH);

      // j
      bus.opcode = 6'd2;
      cyc("j_fetch",  4'd0, C_FET_RDY);
      cyc("j_decode", 4'd1, C_DEC);
      cyc("j_jump",   4'd9, C_JUMP);

      // Illegal opcode: one-cycle pulse in DECODE, straight back to FETCH
      bus.opcode = 6'd63;
      cyc("ill_fetch",  4'd0, C_FET_RDY);
      cyc("ill_decode", 4'd1, C_DEC_ILL);

      // addi; mem_ready low outside memory states must not stall
      bus.opcode = 6'd8;
      cyc("addi_fetch",  4'd0, C_FET_RDY);
      bus.mem_ready = 1'b0;
      cyc("addi_decode", 4'd1, C_DEC);
      cyc("addi_ex",     4'd10, C_ADDIEX);
      cyc("addi_wb",     4'd11, C_ADDIWB);
      cyc("addi_refetch_w", 4'd0, C_FET_WT);

      // Reset in the middle of a stalled MEM_RD
      bus.opcode = 6'd35; bus.mem_ready = 1'b1;
      cyc("rlw_fetch",  4'd0, C_FET_RDY);
      cyc("rlw_decode", 4'd1, C_DEC);
      cyc("rlw_addr",   4'd2, C_MADDR);
      bus.mem_ready = 1'b0;
      cyc("rlw_rd",     4'd3, C_MRD);
      rst = 1'b1;
      cyc("rlw_rst1",   4'd0, C_ZERO);
      cyc("rlw_rst2",   4'd0, C_ZERO);
      rst = 1'b0;
      cyc("rlw_post_w", 4'd0, C_FET_WT);
      bus.mem_ready = 1'b1;
      cyc("rlw_post",   4'd0, C_FET_RDY);
      cyc("rlw_dec2",   4'd1, C_DEC);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule
